health_ctrl: RTL and testbench
==============================

Name: health_ctrl

Overview:
Owns the player's life count. Its 2-bit num_hearts output drives the heart-bar renderer.
- Takes collision hits, heart pickups and new-game requests from game logic.
- Decrements and saturates the heart count.
- Runs a frame-counted invulnerability window with a blink strobe after each hit.
- Flags game over when the last heart is lost.
- Sits in the game-logic layer, clocked by the pixel clock and advanced by a once-per-frame tick.

Parameters:
MAX_HEARTS, 3, heart count loaded at reset and on new_game; legal range 1..3.
INVULN_FRAMES, 120, frame ticks of invulnerability after a non-fatal hit; range 1..255.
BLINK_FRAMES, 8, frame ticks per blink half-period during invulnerability; range 1..15.
REGEN_FRAMES, 600, frame ticks without a hit before one heart regenerates (HEALTH_REGEN_EN only); range 1..1023.

Ports:
clk  in  1  system/pixel clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse, once per frame (end of vsync)
hit  in  1  one-cycle pulse: player collided with a hazard
heal  in  1  one-cycle pulse: player collected a heart pickup
new_game  in  1  one-cycle pulse: restart with full health
num_hearts  out  2  current heart count 0..MAX_HEARTS
invuln  out  1  high while the invulnerability window runs
hearts_blink  out  1  blink strobe for the player/heart sprite; high = hide
game_over  out  1  high while in DEAD

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: num_hearts=MAX_HEARTS, state ALIVE, invuln=0, hearts_blink=0, game_over=0, all counters 0.
- Register timing: all outputs are registered and reflect inputs sampled one clk earlier.
- States:
  - ALIVE: normal play.
  - INVULN: post-hit grace period.
  - DEAD: zero hearts.
- Input priority in each cycle: rst > new_game > hit > heal > frame_tick counting.
- new_game (any state): num_hearts=MAX_HEARTS, go to ALIVE, clear counters and outputs. Any hit/heal in the same cycle is discarded.
- ALIVE + hit:
  - num_hearts==1: num_hearts=0, go to DEAD, game_over=1.
  - Otherwise: num_hearts-=1, go to INVULN, inv_cnt=INVULN_FRAMES, blink_cnt=BLINK_FRAMES, hearts_blink=1.
  - A heal in the same cycle is dropped.
- INVULN + hit: ignored, with no count change and no counter reload.
- heal in ALIVE or INVULN: num_hearts=min(num_hearts+1, MAX_HEARTS). Saturation at MAX_HEARTS is silent.
- heal in DEAD: ignored.
- INVULN + frame_tick:
  - inv_cnt decrements.
  - blink_cnt decrements. When it reaches 0, hearts_blink toggles and blink_cnt reloads BLINK_FRAMES.
  - When inv_cnt goes 1→0: go to ALIVE, invuln=0, hearts_blink=0 on the same edge.
- A hit coinciding with the final frame_tick of INVULN is ignored, because state was INVULN when sampled.
- invuln is 1 exactly while state==INVULN; game_over is 1 exactly while state==DEAD.
- DEAD: everything except new_game and rst is ignored. num_hearts holds 0.
- Arithmetic: num_hearts never wraps. No decrement below 0, no increment above MAX_HEARTS.
- Counter widths: inv_cnt 8 bits, blink_cnt 4 bits, regen_cnt 10 bits.
- rst asserted mid-INVULN aborts the window immediately; next cycle shows reset values.

Optional Feature:
HEALTH_REGEN_EN:
- When defined:
  - regen_cnt counts frame_ticks in ALIVE while num_hearts<MAX_HEARTS.
  - It is cleared by any accepted hit, any heal, new_game, entry to INVULN, and rst.
  - On reaching REGEN_FRAMES it adds one heart (saturating) and clears.
  - It does not count in INVULN or DEAD.
- When undefined: no regen_cnt logic exists. Hearts are only restored by heal or new_game.

Test Plan:
1. Reset, then 3 hits spaced 130 frame_ticks apart.
   - Expected: num_hearts 3→2→1→0.
   - invuln high 120 ticks after the 1st and 2nd hits.
   - game_over=1 after the 3rd hit; no INVULN entered.
2. One hit, then another hit 50 ticks later.
   - Expected: second hit ignored, num_hearts stays 2.
   - invuln drops exactly on the 120th tick after the first hit.
3. During INVULN, count frame_ticks.
   - Expected: hearts_blink toggles every 8 ticks, starting high.
   - hearts_blink=0 once invuln falls.
4. Hit and heal pulsed together at num_hearts=3, state ALIVE.
   - Expected: num_hearts=2, INVULN entered.
   - Then heal twice: num_hearts 3, then stays 3 (saturation).
5. In DEAD, pulse hit and heal.
   - Expected: no change.
   - Then pulse new_game together with hit: num_hearts=3, ALIVE, game_over=0, invuln=0.
6. HEALTH_REGEN_EN: after one hit, wait 120 ticks, then 600 further ticks with no events.
   - Expected: num_hearts 2→3 on tick 600.
   - A hit at tick 599 restarts the count instead.

Source files
------------

// File: rtl/health_ctrl.sv
// Player life-count controller: hits, heals, new-game restart, frame-counted invulnerability with blink strobe.
// Optional heart regeneration over time is enabled by defining HEALTH_REGEN_EN.
module health_ctrl #(
    parameter int unsigned MAX_HEARTS    = 3,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES  = 8,
    parameter int unsigned REGEN_FRAMES  = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       heal,
    input  logic       new_game,
    output logic [1:0] num_hearts,
    output logic       invuln,
    output logic       hearts_blink,
    output logic       game_over
);

    localparam int unsigned HW = 2;
    localparam int unsigned IW = 8;
    localparam int unsigned BW = 4;

    localparam logic [HW-1:0] HEARTS_MAX = HW'(MAX_HEARTS);
    localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hearts_q, hearts_d;
    logic [IW-1:0] inv_cnt_q, inv_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          invuln_q, invuln_d;
    logic          game_over_q, game_over_d;
    logic [HW-1:0] hearts_inc;

`ifdef HEALTH_REGEN_EN
    localparam int unsigned RW = 10;
    localparam logic [RW-1:0] REGEN_LAST = RW'(REGEN_FRAMES - 1);
    logic [RW-1:0] regen_cnt_q, regen_cnt_d;
`endif

    assign hearts_inc = (hearts_q < HEARTS_MAX) ? hearts_q + HW'(1) : hearts_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = ALIVE;
        end else begin
            case (state_q)
                ALIVE:   if (hit) state_d = (hearts_q <= HW'(1)) ? DEAD : INVULN;
                INVULN:  if (frame_tick && inv_cnt_q == IW'(1)) state_d = ALIVE;
                DEAD:    state_d = DEAD;
                default: state_d = ALIVE;
            endcase
        end
    end

    // Datapath and output next values; heal still applies in INVULN since the hit there is ignored
    always_comb begin
        hearts_d    = hearts_q;
        inv_cnt_d   = inv_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
`ifdef HEALTH_REGEN_EN
        regen_cnt_d = regen_cnt_q;
`endif
        if (new_game) begin
            hearts_d    = HEARTS_MAX;
            inv_cnt_d   = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
`ifdef HEALTH_REGEN_EN
            regen_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit) begin
                        hearts_d = (hearts_q != '0) ? hearts_q - HW'(1) : hearts_q;
                        if (state_d == INVULN) begin
                            inv_cnt_d   = INV_LOAD;
                            blink_cnt_d = BLINK_LOAD;
                            blink_d     = 1'b1;
                        end
`ifdef HEALTH_REGEN_EN
                        regen_cnt_d = '0;
`endif
                    end else if (heal) begin
                        hearts_d = hearts_inc;
`ifdef HEALTH_REGEN_EN
                        regen_cnt_d = '0;
`endif
                    end
`ifdef HEALTH_REGEN_EN
                    else if (frame_tick && hearts_q < HEARTS_MAX) begin
                        if (regen_cnt_q == REGEN_LAST) begin
                            hearts_d    = hearts_inc;
                            regen_cnt_d = '0;
                        end else begin
                            regen_cnt_d = regen_cnt_q + RW'(1);
                        end
                    end
`endif
                end
                INVULN: begin
                    if (heal) hearts_d = hearts_inc;
                    if (frame_tick) begin
                        inv_cnt_d = inv_cnt_q - IW'(1);
                        if (inv_cnt_q == IW'(1)) begin
                            blink_cnt_d = '0;
                            blink_d     = 1'b0;
                        end else if (blink_cnt_q == BW'(1)) begin
                            blink_cnt_d = BLINK_LOAD;
                            blink_d     = ~blink_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q - BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        invuln_d    = (state_d == INVULN);
        game_over_d = (state_d == DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hearts_q    <= HEARTS_MAX;
            inv_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            hearts_q    <= hearts_d;
            inv_cnt_q   <= inv_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

`ifdef HEALTH_REGEN_EN
    always_ff @(posedge clk) begin
        if (rst) regen_cnt_q <= '0;
        else     regen_cnt_q <= regen_cnt_d;
    end
`endif

    assign num_hearts   = hearts_q;
    assign invuln       = invuln_q;
    assign hearts_blink = blink_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_health_ctrl.sv
// Scoreboard bench for health_ctrl: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_health_ctrl;

    localparam int INV   = 120;
    localparam int BLINK = 8;

    logic       clk = 1'b0;
    logic       rst, frame_tick, hit, heal, new_game;
    logic [1:0] num_hearts;
    logic       invuln, hearts_blink, game_over;

    typedef struct {
        string      name;
        logic [1:0] hearts;
        logic       inv;
        logic       blink;
        logic       go;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    health_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .hit         (hit),
        .heal        (heal),
        .new_game    (new_game),
        .num_hearts  (num_hearts),
        .invuln      (invuln),
        .hearts_blink(hearts_blink),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (num_hearts !== mon_e.hearts || invuln !== mon_e.inv ||
                hearts_blink !== mon_e.blink || game_over !== mon_e.go) begin
                n_fail++;
                $display("FAIL %s: got hearts=%0d invuln=%0b blink=%0b game_over=%0b, want hearts=%0d invuln=%0b blink=%0b game_over=%0b",
                         mon_e.name, num_hearts, invuln, hearts_blink, game_over,
                         mon_e.hearts, mon_e.inv, mon_e.blink, mon_e.go);
            end
        end
    end

    task automatic push(input string nm, input int h, input bit i, input bit b, input bit g);
        exp_t e;
        e.name   = nm;
        e.hearts = 2'(h);
        e.inv    = i;
        e.blink  = b;
        e.go     = g;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit ft, input bit h, input bit hl, input bit ng);
        @(negedge clk);
        frame_tick = ft; hit = h; heal = hl; new_game = ng;
        @(posedge clk);
        #1;
        frame_tick = 1'b0; hit = 1'b0; heal = 1'b0; new_game = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Full invulnerability window after a hit; optional extra hit on tick hit_at (0 = none)
    task automatic inv_window(input string nm, input int hearts, input int hit_at);
        for (int k = 1; k <= INV; k++) begin
            cyc(1'b1, k == hit_at, 1'b0, 1'b0);
            if (k < INV) push(nm, hearts, 1'b1, ((k / BLINK) % 2) == 0, 1'b0);
            else         push({nm, "_end"}, hearts, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle_ticks(input string nm, input int n, input int hearts);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            push(nm, hearts, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_tick = 1'b0; hit = 1'b0; heal = 1'b0; new_game = 1'b0;
        do_reset();
        push("reset", 3, 0, 0, 0);

        // Three hits spaced 130 ticks apart
        cyc(0, 1, 0, 0); push("hit1", 2, 1, 1, 0);
        inv_window("win1", 2, 0);
        idle_ticks("gap1", 10, 2);
        cyc(0, 1, 0, 0); push("hit2", 1, 1, 1, 0);
        inv_window("win2", 1, 0);
        idle_ticks("gap2", 10, 1);
        cyc(0, 1, 0, 0); push("hit3_dead", 0, 0, 0, 1);

        // DEAD ignores everything but new_game
        cyc(0, 1, 0, 0); push("dead_hit", 0, 0, 0, 1);
        cyc(0, 0, 1, 0); push("dead_heal", 0, 0, 0, 1);
        cyc(1, 0, 0, 0); push("dead_tick", 0, 0, 0, 1);
        cyc(0, 1, 1, 1); push("newgame_hit", 3, 0, 0, 0);

        // Hit during window ignored, also on the final tick
        cyc(0, 1, 0, 0); push("hit_a", 2, 1, 1, 0);
        for (int k = 1; k <= INV; k++) begin
            cyc(1'b1, k == 50 || k == INV, 1'b0, 1'b0);
            if (k < INV) push("win_rehit", 2, 1'b1, ((k / BLINK) % 2) == 0, 1'b0);
            else         push("win_rehit_end", 2, 1'b0, 1'b0, 1'b0);
        end

        // Heal, hit+heal together, saturation
        cyc(0, 0, 1, 0); push("heal_to3", 3, 0, 0, 0);
        cyc(0, 1, 1, 0); push("hit_heal", 2, 1, 1, 0);
        cyc(0, 0, 1, 0); push("heal_inv", 3, 1, 1, 0);
        cyc(0, 0, 1, 0); push("heal_sat_inv", 3, 1, 1, 0);
        inv_window("win3", 3, 0);
        cyc(0, 0, 1, 0); push("heal_sat", 3, 0, 0, 0);
        idle_ticks("full_idle", 5, 3);

        // Regeneration after a quiet stretch
        cyc(0, 1, 0, 0); push("hit_r", 2, 1, 1, 0);
        inv_window("win_r", 2, 0);
        idle_ticks("regen_wait", 599, 2);
`ifdef HEALTH_REGEN_EN
        cyc(1, 0, 0, 0); push("regen_600", 3, 0, 0, 0);
        cyc(0, 1, 0, 0); push("hit_r2", 2, 1, 1, 0);
        inv_window("win_r2", 2, 0);
        idle_ticks("regen_wait2", 598, 2);
        cyc(1, 1, 0, 0); push("hit_at_599", 1, 1, 1, 0);
        inv_window("win_r3", 1, 0);
        idle_ticks("regen_wait3", 599, 1);
        cyc(1, 0, 0, 0); push("regen_restart", 2, 0, 0, 0);
`else
        cyc(1, 0, 0, 0); push("no_regen_600", 2, 0, 0, 0);
        idle_ticks("no_regen", 100, 2);
`endif

        // Reset in the middle of a window
        cyc(0, 1, 0, 0); push("hit_m", 1, 1, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 0, 0, 0); push("win_m", 1, 1, 1, 0);
        end
        do_reset();
        push("reset_mid_inv", 3, 0, 0, 0);
        idle_ticks("post_reset", 3, 3);

        @(negedge clk);
        n_checks++;
        if (num_hearts !== 2'd3 || invuln !== 1'b0 || hearts_blink !== 1'b0 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL final_state: hearts=%0d invuln=%0b blink=%0b game_over=%0b",
                     num_hearts, invuln, hearts_blink, game_over);
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d expectations left unchecked", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        if (n_fail != 0) $display("FAIL: %0d mismatches", n_fail);
        else             $display("PASS");
        $finish;
    end

endmodule
